// File: rtl/circle_seq_pkg.sv
// Shared definitions for the circle point sequencer: FSM encoding, FIFO entry layout,
// VdC base codes and the helper tables used by the circle core.
package circle_seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_PUSH  = 2'd3;

   localparam logic [1:0] BASE_2 = 2'b00;
   localparam logic [1:0] BASE_3 = 2'b01;
   localparam logic [1:0] BASE_7 = 2'b10;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] k;
   } pt_entry_t;

   localparam int ENTRY_W = $bits(pt_entry_t);

   // 1/K of the 16-stage CORDIC in 16.16, so the rotated vector lands on unit length
   localparam logic signed [31:0] CORDIC_GAIN_INIT = 32'sd39797;

   function automatic logic [31:0] vdcScaleInit(input logic [1:0] base);
      case (base)
         BASE_3:  return 32'd1431655765;
         BASE_7:  return 32'd613566756;
         default: return 32'h8000_0000;
      endcase
   endfunction

   // atan(2^-i) expressed in units of 2^-32 turn
   function automatic logic [31:0] cordicAtan(input logic [3:0] i);
      case (i)
         4'd0:    return 32'd536870912;
         4'd1:    return 32'd316933406;
         4'd2:    return 32'd167458908;
         4'd3:    return 32'd85004757;
         4'd4:    return 32'd42667331;
         4'd5:    return 32'd21354466;
         4'd6:    return 32'd10679839;
         4'd7:    return 32'd5340246;
         4'd8:    return 32'd2670163;
         4'd9:    return 32'd1335087;
         4'd10:   return 32'd667544;
         4'd11:   return 32'd333772;
         4'd12:   return 32'd166886;
         4'd13:   return 32'd83443;
         4'd14:   return 32'd41722;
         default: return 32'd20861;
      endcase
   endfunction

endpackage

// File: rtl/circle_seq_driver_32bit_if.sv
// Point stream bus between the sequencer (master) and its consumer (slave).
interface circle_seq_driver_32bit_if;
   logic        pt_valid;
   logic        pt_ready;
   logic [31:0] pt_x;
   logic [31:0] pt_y;
   logic [31:0] pt_k;

   modport master (output pt_valid, pt_x, pt_y, pt_k, input pt_ready);
   modport slave  (input pt_valid, pt_x, pt_y, pt_k, output pt_ready);
endinterface

// File: rtl/circle_fsm_32bit_simple.sv
// One-shot unit-circle core: angle = 2*pi*VdC(k, base), then 16-stage CORDIC to 16.16 cos/sin.
module circle_fsm_32bit_simple
   import circle_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [31:0] i_k,
   input  logic [1:0]  i_base,
   output logic        o_ready,
   output logic        o_done,
   output logic [31:0] o_x,
   output logic [31:0] o_y
);
   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_VDC  = 2'd1;
   localparam logic [1:0] C_ROT  = 2'd2;
   localparam logic [1:0] C_OUT  = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         r_base;
   logic [1:0]         r_quad;
   logic [31:0]        r_n;
   logic [31:0]        r_frac;
   logic [31:0]        r_scale;
   logic signed [31:0] r_x;
   logic signed [31:0] r_y;
   logic signed [31:0] r_z;
   logic [3:0]         r_iter;
   logic               r_done;
   logic [31:0]        r_outX;
   logic [31:0]        r_outY;

   logic [31:0]        w_nDiv;
   logic [31:0]        w_scaleDiv;
   logic [31:0]        w_radix;
   logic [31:0]        w_digit;
   logic [31:0]        w_phaseRnd;
   logic signed [31:0] w_resid;
   logic signed [31:0] w_xShift;
   logic signed [31:0] w_yShift;

   always_comb begin
      w_nDiv     = r_n >> 1;
      w_scaleDiv = r_scale >> 1;
      w_radix    = 32'd2;
      case (r_base)
         BASE_3: begin w_nDiv = r_n / 32'd3; w_scaleDiv = r_scale / 32'd3; w_radix = 32'd3; end
         BASE_7: begin w_nDiv = r_n / 32'd7; w_scaleDiv = r_scale / 32'd7; w_radix = 32'd7; end
         default: ;
      endcase
   end

   // fold the phase to the nearest quarter turn so CORDIC only sees +-45 degrees
   assign w_digit    = r_n - w_nDiv * w_radix;
   assign w_phaseRnd = r_frac + 32'h2000_0000;
   assign w_resid    = $signed(r_frac - {w_phaseRnd[31:30], 30'd0});
   assign w_xShift   = r_x >>> r_iter;
   assign w_yShift   = r_y >>> r_iter;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_IDLE;
         r_base  <= '0;
         r_quad  <= '0;
         r_n     <= '0;
         r_frac  <= '0;
         r_scale <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_iter  <= '0;
         r_done  <= 1'b0;
         r_outX  <= '0;
         r_outY  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            C_IDLE: if (i_start) begin
               r_n     <= i_k;
               r_base  <= i_base;
               r_frac  <= '0;
               r_scale <= vdcScaleInit(i_base);
               r_state <= C_VDC;
            end
            C_VDC: if (r_n == '0) begin
               r_quad  <= w_phaseRnd[31:30];
               r_x     <= CORDIC_GAIN_INIT;
               r_y     <= '0;
               r_z     <= w_resid;
               r_iter  <= '0;
               r_state <= C_ROT;
            end else begin
               r_n     <= w_nDiv;
               r_frac  <= r_frac + w_digit * r_scale;
               r_scale <= w_scaleDiv;
            end
            C_ROT: begin
               if (r_z[31]) begin
                  r_x <= r_x + w_yShift;
                  r_y <= r_y - w_xShift;
                  r_z <= r_z + $signed(cordicAtan(r_iter));
               end else begin
                  r_x <= r_x - w_yShift;
                  r_y <= r_y + w_xShift;
                  r_z <= r_z - $signed(cordicAtan(r_iter));
               end
               r_iter <= r_iter + 1'b1;
               if (r_iter == 4'd15) r_state <= C_OUT;
            end
            default: begin
               case (r_quad)
                  2'd0:    begin r_outX <= r_x;  r_outY <= r_y;  end
                  2'd1:    begin r_outX <= -r_y; r_outY <= r_x;  end
                  2'd2:    begin r_outX <= -r_x; r_outY <= -r_y; end
                  default: begin r_outX <= r_y;  r_outY <= -r_x; end
               endcase
               r_done  <= 1'b1;
               r_state <= C_IDLE;
            end
         endcase
      end
   end

   assign o_ready = (r_state == C_IDLE);
   assign o_done  = r_done;
   assign o_x     = r_outX;
   assign o_y     = r_outY;
endmodule

// File: rtl/circle_pt_fifo.sv
// DEPTH x W synchronous FIFO with flush and occupancy output; head is read combinationally.
module circle_pt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 96
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]   r_mem [DEPTH];
   logic [PTR_W:0] r_wrPtr;
   logic [PTR_W:0] r_rdPtr;
   logic           w_full;
   logic           w_doPush;
   logic           w_doPop;

   assign o_level  = r_wrPtr - r_rdPtr;
   assign o_empty  = (o_level == '0);
   assign w_full   = (o_level == (PTR_W+1)'(DEPTH));
   assign w_doPush = i_push & ~w_full;
   assign w_doPop  = i_pop & ~o_empty;
   assign o_data   = r_mem[r_rdPtr[PTR_W-1:0]];

   // pointers carry one extra wrap bit so full and empty stay distinguishable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr[PTR_W-1:0]] <= i_data;
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) r_rdPtr <= r_rdPtr + 1'b1;
      end
   end
endmodule

// File: rtl/circle_seq_driver_32bit.sv
// Streaming front end: issues one core start per index k and buffers (cos,sin,k) in a FIFO.
// Optional accepted-point counter enabled by defining CIRCLE_SEQ_STATS_EN.
module circle_seq_driver_32bit
   import circle_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int K_W        = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          seed_load,
   input  logic [K_W-1:0]                seed_k,
   input  logic [1:0]                    base_sel,
   input  logic                          run,
   circle_seq_driver_32bit_if.master     pt_if,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic [31:0]                   pt_count
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]     r_state;
   logic [K_W-1:0] r_k;
   logic [1:0]     r_base;
   logic [31:0]    r_capX;
   logic [31:0]    r_capY;
   logic [K_W-1:0] r_capK;

   logic           w_coreStart;
   logic           w_coreReady;
   logic           w_coreDone;
   logic [31:0]    w_coreX;
   logic [31:0]    w_coreY;
   logic           w_credit;
   logic           w_flush;
   logic           w_push;
   logic           w_pop;
   logic           w_empty;
   pt_entry_t      w_wrEntry;
   pt_entry_t      w_rdEntry;

   // the point being pushed still counts against capacity, so a push never finds the FIFO full
   assign w_credit = ({1'b0, fifo_level} + {{LVL_W{1'b0}}, (r_state == ST_PUSH)})
                     < (LVL_W+1)'(FIFO_DEPTH);
   assign w_flush     = (r_state == ST_IDLE) & seed_load;
   assign w_push      = (r_state == ST_PUSH);
   assign w_pop       = pt_if.pt_valid & pt_if.pt_ready;
   assign w_coreStart = (r_state == ST_ISSUE);
   assign busy        = (r_state != ST_IDLE);
   assign w_wrEntry   = '{x: r_capX, y: r_capY, k: r_capK};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_base  <= '0;
         r_capX  <= '0;
         r_capY  <= '0;
         r_capK  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (seed_load) begin
               r_k <= seed_k;
            end else if (run && w_coreReady && w_credit) begin
               r_base  <= base_sel;
               r_state <= ST_ISSUE;
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT: if (w_coreDone) begin
               r_capX  <= w_coreX;
               r_capY  <= w_coreY;
               r_capK  <= r_k;
               r_state <= ST_PUSH;
            end
            default: begin
               r_k <= r_k + K_W'(1);
               if (run && w_coreReady && w_credit) begin
                  r_base  <= base_sel;
                  r_state <= ST_ISSUE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   circle_fsm_32bit_simple u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_coreStart),
      .i_k     (r_k),
      .i_base  (r_base),
      .o_ready (w_coreReady),
      .o_done  (w_coreDone),
      .o_x     (w_coreX),
      .o_y     (w_coreY)
   );

   circle_pt_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (w_wrEntry),
      .i_pop   (w_pop),
      .o_data  (w_rdEntry),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign pt_if.pt_valid = ~w_empty;
   assign pt_if.pt_x     = w_rdEntry.x;
   assign pt_if.pt_y     = w_rdEntry.y;
   assign pt_if.pt_k     = w_rdEntry.k;

`ifdef CIRCLE_SEQ_STATS_EN
   logic [31:0] r_ptCount;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_ptCount <= '0;
      else if (w_flush) r_ptCount <= '0;
      else if (w_pop)   r_ptCount <= r_ptCount + 32'd1;
   end

   assign pt_count = r_ptCount;
`else
   assign pt_count = 32'h0;
`endif
endmodule

// File: tb/tb_circle_seq_driver_32bit.sv
// Directed bench for circle_seq_driver_32bit: reset, streaming, backpressure, run drop, k wrap, flush, stats.
module tb_circle_seq_driver_32bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [31:0] seed_k;
   logic [1:0]  base_sel;
   logic        run;
   logic [2:0]  fifo_level;
   logic        busy;
   logic [31:0] pt_count;

   int passCount  = 0;
   int checkCount = 0;
   int startCount = 0;

`ifdef CIRCLE_SEQ_STATS_EN
   localparam int EXP_POPS = 10;
`else
   localparam int EXP_POPS = 0;
`endif

   circle_seq_driver_32bit_if ptIf ();

   circle_seq_driver_32bit #(.FIFO_DEPTH(4), .K_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seed_load  (seed_load),
      .seed_k     (seed_k),
      .base_sel   (base_sel),
      .run        (run),
      .pt_if      (ptIf),
      .fifo_level (fifo_level),
      .busy       (busy),
      .pt_count   (pt_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (dut.w_coreStart === 1'b1) startCount++;

   function automatic bit near(input logic [31:0] a, input logic [31:0] e);
      logic signed [31:0] d;
      d = a - e;
      return (d <= 32'sd256) && (d >= -32'sd256);
   endfunction

   task automatic waitValid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ptIf.pt_valid === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic waitIdle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic seedAt(input logic [31:0] k, input logic [1:0] b, input logic runLvl);
      @(negedge clk);
      seed_k = k; base_sel = b; seed_load = 1'b1; run = runLvl;
      @(negedge clk);
      seed_load = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; seed_load = 1'b0; seed_k = '0; base_sel = '0; run = 1'b0; ptIf.pt_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkCount++; if (ptIf.pt_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", ptIf.pt_valid); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
      checkCount++; if (fifo_level !== 3'd0) $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); else passCount++;
      checkCount++; if (pt_count !== 32'h0) $display("[TB] FAIL reset_count: got %h want 0", pt_count); else passCount++;
      checkCount++; if (ptIf.pt_k !== 32'h0) $display("[TB] FAIL reset_k: got %h want 0", ptIf.pt_k); else passCount++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkCount++; if (ptIf.pt_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL release_idle: got valid=%b busy=%b want 0 0", ptIf.pt_valid, busy); else passCount++;
      checkCount++; if (fifo_level !== 3'd0 || ptIf.pt_x !== 32'h0) $display("[TB] FAIL release_out: got level=%0d x=%h want 0 0", fifo_level, ptIf.pt_x); else passCount++;
   endtask

   task automatic test_basic_stream;
      bit ok;
      ptIf.pt_ready = 1'b1;
      @(negedge clk);
      seed_k = 32'd1; base_sel = 2'b00; seed_load = 1'b1; run = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL load_wins: got busy=%b want 0", busy); else passCount++;
      waitValid(300, ok);
      checkCount++; if (!ok) $display("[TB] FAIL first_point_timeout: got no valid want valid"); else passCount++;
      checkCount++; if (ptIf.pt_k !== 32'd1) $display("[TB] FAIL first_k: got %h want 00000001", ptIf.pt_k); else passCount++;
      checkCount++; if (!near(ptIf.pt_x, 32'hFFFF0000) || !near(ptIf.pt_y, 32'h0))
         $display("[TB] FAIL first_xy: got x=%h y=%h want ~ffff0000 ~00000000", ptIf.pt_x, ptIf.pt_y); else passCount++;
      waitValid(300, ok);
      checkCount++; if (!ok || ptIf.pt_k !== 32'd2) $display("[TB] FAIL second_k: got %h want 00000002", ptIf.pt_k); else passCount++;
      checkCount++; if (!near(ptIf.pt_x, 32'h0) || !near(ptIf.pt_y, 32'h00010000))
         $display("[TB] FAIL second_xy: got x=%h y=%h want ~00000000 ~00010000", ptIf.pt_x, ptIf.pt_y); else passCount++;
      run = 1'b0;
      waitIdle(300, ok);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_backpressure;
      bit ok;
      int s0, got, guard;
      logic [31:0] expK;
      ptIf.pt_ready = 1'b0;
      seedAt(32'd100, 2'b00, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (fifo_level == 3'd4) begin ok = 1'b1; break; end
      end
      s0 = startCount;
      repeat (150) @(negedge clk);
      checkCount++; if (!ok || fifo_level !== 3'd4) $display("[TB] FAIL bp_level: got %0d want 4", fifo_level); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL bp_busy: got %b want 0", busy); else passCount++;
      checkCount++; if (startCount !== s0) $display("[TB] FAIL bp_no_start: got %0d starts want %0d", startCount, s0); else passCount++;
      checkCount++; if (ptIf.pt_k !== 32'd100) $display("[TB] FAIL bp_head: got %h want 00000064", ptIf.pt_k); else passCount++;
      ptIf.pt_ready = 1'b1;
      expK = 32'd100; got = 0; guard = 0;
      while (got < 7 && guard < 2000) begin
         if (ptIf.pt_valid === 1'b1) begin
            checkCount++; if (ptIf.pt_k !== expK) $display("[TB] FAIL bp_seq: got %h want %h", ptIf.pt_k, expK); else passCount++;
            expK++; got++;
         end
         @(negedge clk); guard++;
      end
      checkCount++; if (got != 7) $display("[TB] FAIL bp_resume_timeout: got %0d points want 7", got); else passCount++;
      run = 1'b0;
      waitIdle(300, ok);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_run_drop;
      bit ok;
      int s0;
      ptIf.pt_ready = 1'b1;
      s0 = startCount;
      seedAt(32'd1, 2'b01, 1'b1);
      for (int i = 0; i < 50 && startCount == s0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      run = 1'b0;
      waitValid(300, ok);
      checkCount++; if (!ok || ptIf.pt_k !== 32'd1) $display("[TB] FAIL drop_point: got k=%h want 00000001", ptIf.pt_k); else passCount++;
      checkCount++; if (!near(ptIf.pt_x, 32'hFFFF8000) || !near(ptIf.pt_y, 32'h0000DDB4))
         $display("[TB] FAIL base3_xy: got x=%h y=%h want ~ffff8000 ~0000ddb4", ptIf.pt_x, ptIf.pt_y); else passCount++;
      waitIdle(50, ok);
      checkCount++; if (!ok) $display("[TB] FAIL drop_busy: got busy=%b want 0", busy); else passCount++;
      repeat (200) @(negedge clk);
      checkCount++; if (startCount !== s0 + 1) $display("[TB] FAIL drop_starts: got %0d want %0d", startCount, s0 + 1); else passCount++;
      checkCount++; if (fifo_level !== 3'd0) $display("[TB] FAIL drop_level: got %0d want 0", fifo_level); else passCount++;
   endtask

   task automatic test_wrap;
      bit ok;
      int got, guard;
      logic [31:0] expK;
      ptIf.pt_ready = 1'b1;
      seedAt(32'hFFFF_FFFE, 2'b00, 1'b1);
      expK = 32'hFFFF_FFFE; got = 0; guard = 0;
      while (got < 3 && guard < 2000) begin
         if (ptIf.pt_valid === 1'b1) begin
            checkCount++; if (ptIf.pt_k !== expK) $display("[TB] FAIL wrap_k: got %h want %h", ptIf.pt_k, expK); else passCount++;
            expK++; got++;
         end
         @(negedge clk); guard++;
      end
      checkCount++; if (got != 3) $display("[TB] FAIL wrap_timeout: got %0d points want 3", got); else passCount++;
      run = 1'b0;
      waitIdle(300, ok);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_flush;
      bit ok;
      ptIf.pt_ready = 1'b0;
      seedAt(32'd50, 2'b10, 1'b1);
      for (int i = 0; i < 1000 && fifo_level < 3'd2; i++) @(negedge clk);
      run = 1'b0;
      waitIdle(300, ok);
      checkCount++; if (fifo_level < 3'd2 || ptIf.pt_valid !== 1'b1) $display("[TB] FAIL flush_pre: got level=%0d want >=2", fifo_level); else passCount++;
      seedAt(32'd0, 2'b00, 1'b0);
      checkCount++; if (fifo_level !== 3'd0 || ptIf.pt_valid !== 1'b0)
         $display("[TB] FAIL flush_post: got level=%0d valid=%b want 0 0", fifo_level, ptIf.pt_valid); else passCount++;
   endtask

   task automatic test_stats;
      bit ok;
      int pops, guard;
      ptIf.pt_ready = 1'b0;
      seedAt(32'd5, 2'b00, 1'b0);
      checkCount++; if (pt_count !== 32'h0) $display("[TB] FAIL stats_clear0: got %h want 0", pt_count); else passCount++;
      ptIf.pt_ready = 1'b1; run = 1'b1;
      pops = 0; guard = 0;
      while (pops < 10 && guard < 3000) begin
         if (ptIf.pt_valid === 1'b1) pops++;
         if (pops == 10) begin
            @(posedge clk); #1;
            ptIf.pt_ready = 1'b0; run = 1'b0;
         end else begin
            @(negedge clk);
         end
         guard++;
      end
      waitIdle(300, ok);
      repeat (3) @(negedge clk);
      checkCount++; if (pops != 10 || pt_count !== 32'(EXP_POPS))
         $display("[TB] FAIL stats_count: got %0d (pops=%0d) want %0d", pt_count, pops, EXP_POPS); else passCount++;
      seedAt(32'd0, 2'b00, 1'b0);
      checkCount++; if (pt_count !== 32'h0) $display("[TB] FAIL stats_clear: got %h want 0", pt_count); else passCount++;
   endtask

   initial begin
      test_reset();
      test_basic_stream();
      test_backpressure();
      test_run_drop();
      test_wrap();
      test_flush();
      test_stats();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
